ddr3_cmd_sequencer: RTL and testbench

Synthesizable command sequencer that drives the DDR3 command/address pins of `ddr3_interface` (`rst_n`, `cke`, `cs_n`, `ras_n`, `cas_n`, `we_n`, `ba`, `addr`, `odt`).

- After reset it runs the JEDEC power-up and initialization sequence: reset hold, CKE wait, tXPR, MR2/MR3/MR1/MR0, ZQCL.
- It then accepts single commands from a controller over a valid/ready handshake.
- It inserts NOP cycles so that each command's minimum spacing is met.
- It sits directly upstream of the DDR3 pin interface and replaces the bench's task-based stimulus.

---
 rtl/ddr3_cmd_sequencer.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_ddr3_cmd_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ddr3_cmd_sequencer
//  Purpose  : Drives the DDR3 command/address pins. After reset it walks the
//             power-up/initialisation sequence (reset hold, CKE wait, tXPR,
//             MR2/MR3/MR1/MR0, ZQCL). It then accepts single commands over a
//             valid/ready handshake and pads each one with NOP cycles until
//             the command's minimum spacing is met.
//  Ports    : ck, rst             - clock (rising edge), sync active-high reset
//             cmd_valid/cmd_ready - command handshake (ready only in IDLE)
//             cmd_op/ba/addr      - 0 NOP,1 PRE,2 ACT,3 REF,4 ZQ,5 MRS
//                                   6 and 7 are illegal
//             init_done, cmd_err  - init complete level / illegal-op pulse
//             ddr_rst_n .. addr   - registered DDR3 pins
//  Revision : 1.0 - initial release
// ============================================================================
module ddr3_cmd_sequencer #(
    parameter int                   BA_BITS   = 3,
    parameter int                   ADDR_BITS = 14,
    parameter logic [ADDR_BITS-1:0] MR0_VAL   = 'h0520,
    parameter logic [ADDR_BITS-1:0] MR1_VAL   = 'h0004,
    parameter logic [ADDR_BITS-1:0] MR2_VAL   = 'h0000,
    parameter logic [ADDR_BITS-1:0] MR3_VAL   = 'h0000,
    parameter int                   T_RST     = 200,
    parameter int                   T_CKE     = 500,
    parameter int                   T_XPR     = 120,
    parameter int                   T_MRD     = 4,
    parameter int                   T_MOD     = 12,
    parameter int                   T_ZQINIT  = 512,
    parameter int                   T_ZQCS    = 64,
    parameter int                   T_RP      = 6,
    parameter int                   T_RCD     = 6,
    parameter int                   T_RFC     = 44
) (
    input  logic                 ck,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [BA_BITS-1:0]   cmd_ba,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    output logic                 init_done,
    output logic                 cmd_err,
    output logic                 ddr_rst_n,
    output logic                 cke,
    output logic                 cs_n,
    output logic                 ras_n,
    output logic                 cas_n,
    output logic                 we_n,
    output logic                 odt,
    output logic [BA_BITS-1:0]   ba,
    output logic [ADDR_BITS-1:0] addr
);

    typedef enum logic [3:0] {
        ST_RST_LO   = 4'd0,
        ST_CKE_WAIT = 4'd1,
        ST_XPR      = 4'd2,
        ST_MRS2     = 4'd3,
        ST_MRS3     = 4'd4,
        ST_MRS1     = 4'd5,
        ST_MRS0     = 4'd6,
        ST_ZQCL     = 4'd7,
        ST_IDLE     = 4'd8
    } state_t;

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One counter width covers every timing parameter.
    localparam int c_T_MAX = f_max(f_max(f_max(T_RST, T_CKE), f_max(T_XPR, T_MRD)),
                                   f_max(f_max(T_MOD, T_ZQINIT),
                                         f_max(f_max(T_ZQCS, T_RP), f_max(T_RCD, T_RFC))));
    localparam int c_CW = $clog2(c_T_MAX + 1);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] c_PIN_MRS = 4'b0000;
    localparam logic [3:0] c_PIN_REF = 4'b0001;
    localparam logic [3:0] c_PIN_PRE = 4'b0010;
    localparam logic [3:0] c_PIN_ACT = 4'b0011;
    localparam logic [3:0] c_PIN_ZQ  = 4'b0110;
    localparam logic [3:0] c_PIN_NOP = 4'b0111;
    localparam logic [3:0] c_PIN_DES = 4'b1111;

    localparam logic [2:0] c_OP_NOP = 3'd0;
    localparam logic [2:0] c_OP_PRE = 3'd1;
    localparam logic [2:0] c_OP_ACT = 3'd2;
    localparam logic [2:0] c_OP_REF = 3'd3;
    localparam logic [2:0] c_OP_ZQ  = 3'd4;
    localparam logic [2:0] c_OP_MRS = 3'd5;

    // ZQCL: A10 high selects the long calibration.
    localparam logic [ADDR_BITS-1:0] c_ZQ_LONG = ADDR_BITS'(1024);

    state_t                r_state;
    logic [c_CW-1:0]       r_cnt;      // cycles left in current init state, incl. current
    logic [c_CW-1:0]       r_gap;      // NOP cycles left before cmd_ready may rise

    state_t                w_state_nx;
    logic [c_CW-1:0]       w_cnt_nx;
    logic [c_CW-1:0]       w_gap_nx;
    logic                  w_enter;
    logic                  w_accept;
    logic [3:0]            w_pins_nx;
    logic [BA_BITS-1:0]    w_ba_nx;
    logic [ADDR_BITS-1:0]  w_addr_nx;
    logic                  w_rst_n_nx;
    logic                  w_cke_nx;
    logic                  w_ready_nx;
    logic                  w_err_nx;
    logic                  w_done_nx;

    function automatic state_t f_next(input state_t s);
        case (s)
            ST_RST_LO:   return ST_CKE_WAIT;
            ST_CKE_WAIT: return ST_XPR;
            ST_XPR:      return ST_MRS2;
            ST_MRS2:     return ST_MRS3;
            ST_MRS3:     return ST_MRS1;
            ST_MRS1:     return ST_MRS0;
            ST_MRS0:     return ST_ZQCL;
            default:     return ST_IDLE;
        endcase
    endfunction

    // Number of cycles spent in each init state. A MRS/ZQCL state includes
    // its own command cycle, so the next command lands exactly one gap later.
    function automatic logic [c_CW-1:0] f_hold(input state_t s);
        case (s)
            ST_RST_LO:   return c_CW'(T_RST);
            ST_CKE_WAIT: return c_CW'(T_CKE);
            ST_XPR:      return c_CW'(T_XPR);
            ST_MRS2,
            ST_MRS3,
            ST_MRS1:     return c_CW'(T_MRD);
            ST_MRS0:     return c_CW'(T_MOD);
            ST_ZQCL:     return c_CW'(T_ZQINIT);
            default:     return c_CW'(1);
        endcase
    endfunction

    // Gap loaded on accept is spacing-1: ready rises in cycle C+G-1 so the
    // next accepted command appears in cycle C+G.
    function automatic logic [c_CW-1:0] f_gap(input logic [2:0] op);
        case (op)
            c_OP_PRE: return c_CW'(T_RP - 1);
            c_OP_ACT: return c_CW'(T_RCD - 1);
            c_OP_REF: return c_CW'(T_RFC - 1);
            c_OP_ZQ:  return c_CW'(T_ZQCS - 1);
            c_OP_MRS: return c_CW'(T_MOD - 1);
            default:  return '0;
        endcase
    endfunction

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_gap_nx   = r_gap;
        w_enter    = 1'b0;
        w_pins_nx  = c_PIN_NOP;
        w_ba_nx    = ba;
        w_addr_nx  = addr;
        w_rst_n_nx = 1'b1;
        w_cke_nx   = 1'b1;
        w_ready_nx = 1'b0;
        w_err_nx   = 1'b0;
        w_done_nx  = 1'b0;
        // cmd_ready is only ever high in IDLE, so this also ignores
        // requests made during initialisation.
        w_accept   = cmd_valid && cmd_ready;

        if (r_state != ST_IDLE) begin
            if (r_cnt == c_CW'(1)) begin
                w_enter    = 1'b1;
                w_state_nx = f_next(r_state);
                w_cnt_nx   = f_hold(w_state_nx);
            end else begin
                w_cnt_nx   = r_cnt - c_CW'(1);
            end
        end

        // Outputs are registered, so they are derived from the state that
        // will be current after the edge.
        case (w_state_nx)
            ST_RST_LO: begin
                w_rst_n_nx = 1'b0;
                w_cke_nx   = 1'b0;
                w_pins_nx  = c_PIN_DES;
            end
            ST_CKE_WAIT: begin
                w_cke_nx   = 1'b0;
                w_pins_nx  = c_PIN_DES;
            end
            ST_XPR: begin
                w_pins_nx  = c_PIN_NOP;
            end
            ST_MRS2: begin
                if (w_enter) begin
                    w_pins_nx = c_PIN_MRS;
                    w_ba_nx   = BA_BITS'(2);
                    w_addr_nx = MR2_VAL;
                end
            end
            ST_MRS3: begin
                if (w_enter) begin
                    w_pins_nx = c_PIN_MRS;
                    w_ba_nx   = BA_BITS'(3);
                    w_addr_nx = MR3_VAL;
                end
            end
            ST_MRS1: begin
                if (w_enter) begin
                    w_pins_nx = c_PIN_MRS;
                    w_ba_nx   = BA_BITS'(1);
                    w_addr_nx = MR1_VAL;
                end
            end
            ST_MRS0: begin
                if (w_enter) begin
                    w_pins_nx = c_PIN_MRS;
                    w_ba_nx   = BA_BITS'(0);
                    w_addr_nx = MR0_VAL;
                end
            end
            ST_ZQCL: begin
                if (w_enter) begin
                    w_pins_nx = c_PIN_ZQ;
                    w_ba_nx   = BA_BITS'(0);
                    w_addr_nx = c_ZQ_LONG;
                end
            end
            ST_IDLE: begin
                w_done_nx = 1'b1;
                if (w_enter) begin
                    w_gap_nx = '0;
                end else if (w_accept) begin
                    w_gap_nx = f_gap(cmd_op);
                    case (cmd_op)
                        c_OP_NOP: w_pins_nx = c_PIN_NOP;
                        c_OP_PRE: w_pins_nx = c_PIN_PRE;
                        c_OP_ACT: w_pins_nx = c_PIN_ACT;
                        c_OP_REF: w_pins_nx = c_PIN_REF;
                        c_OP_ZQ:  w_pins_nx = c_PIN_ZQ;
                        c_OP_MRS: w_pins_nx = c_PIN_MRS;
                        default:  w_err_nx  = 1'b1;
                    endcase
                    // Illegal ops leave the address bus untouched.
                    if (!w_err_nx) begin
                        w_ba_nx   = cmd_ba;
                        w_addr_nx = cmd_addr;
                    end
                end else if (r_gap != '0) begin
                    w_gap_nx = r_gap - c_CW'(1);
                end
                w_ready_nx = (w_gap_nx == '0);
            end
            default: begin
                w_pins_nx = c_PIN_DES;
            end
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state   <= ST_RST_LO;
            r_cnt     <= c_CW'(T_RST);
            r_gap     <= '0;
            ddr_rst_n <= 1'b0;
            cke       <= 1'b0;
            {cs_n, ras_n, cas_n, we_n} <= c_PIN_DES;
            odt       <= 1'b0;
            ba        <= '0;
            addr      <= '0;
            init_done <= 1'b0;
            cmd_ready <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_gap     <= w_gap_nx;
            ddr_rst_n <= w_rst_n_nx;
            cke       <= w_cke_nx;
            {cs_n, ras_n, cas_n, we_n} <= w_pins_nx;
            odt       <= 1'b0;
            ba        <= w_ba_nx;
            addr      <= w_addr_nx;
            init_done <= w_done_nx;
            cmd_ready <= w_ready_nx;
            cmd_err   <= w_err_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr3_cmd_sequencer
//  Purpose  : Self-checking bench for ddr3_cmd_sequencer. A timeline model of
//             the init sequence and a handshake/spacing model of IDLE predict
//             every output each cycle; directed sequences plus random
//             traffic exercise the command path and mid-operation reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_cmd_sequencer;

    localparam int T_RST    = 4;
    localparam int T_CKE    = 6;
    localparam int T_XPR    = 5;
    localparam int T_MRD    = 4;
    localparam int T_MOD    = 12;
    localparam int T_ZQINIT = 20;
    localparam int T_ZQCS   = 64;
    localparam int T_RP     = 6;
    localparam int T_RCD    = 6;
    localparam int T_RFC    = 44;
    localparam logic [13:0] MR0 = 14'h0520;
    localparam logic [13:0] MR1 = 14'h0004;
    localparam logic [13:0] MR2 = 14'h0008;
    localparam logic [13:0] MR3 = 14'h0003;

    // Init timeline, cycles counted from the first cycle out of reset.
    localparam int TM2   = T_RST + T_CKE + T_XPR;
    localparam int TM3   = TM2 + T_MRD;
    localparam int TM1   = TM3 + T_MRD;
    localparam int TM0   = TM1 + T_MRD;
    localparam int TZQ   = TM0 + T_MOD;
    localparam int TIDLE = TZQ + T_ZQINIT;

    logic        ck = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_ba;
    logic [13:0] cmd_addr;
    logic        init_done, cmd_err;
    logic        ddr_rst_n, cke, cs_n, ras_n, cas_n, we_n, odt;
    logic [2:0]  ba;
    logic [13:0] addr;

    ddr3_cmd_sequencer #(
        .BA_BITS(3), .ADDR_BITS(14),
        .MR0_VAL(MR0), .MR1_VAL(MR1), .MR2_VAL(MR2), .MR3_VAL(MR3),
        .T_RST(T_RST), .T_CKE(T_CKE), .T_XPR(T_XPR), .T_MRD(T_MRD),
        .T_MOD(T_MOD), .T_ZQINIT(T_ZQINIT), .T_ZQCS(T_ZQCS), .T_RP(T_RP),
        .T_RCD(T_RCD), .T_RFC(T_RFC)
    ) dut (
        .ck(ck), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
        .init_done(init_done), .cmd_err(cmd_err), .ddr_rst_n(ddr_rst_n),
        .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .odt(odt), .ba(ba), .addr(addr)
    );

    always #5 ck = ~ck;

    int tests = 0;
    int fails = 0;
    int mode  = 0;   // 1 ACT->PRE, 2 REF->ACT, 3 illegal, 4 NOP burst, 5 pre-init

    // Model state (owned by the compare process).
    int          cyc = 0;
    bit          model_on = 1'b0;
    int          next_ready = 0;
    bit          pend_v = 1'b0;
    int          pend_cyc = 0;
    logic [2:0]  pend_op = '0;
    logic [2:0]  pend_ba = '0;
    logic [13:0] pend_addr = '0;
    logic [3:0]  obs_last = 4'b1111;
    int          obs_last_cyc = 0;
    int          nops_since = 0;
    int          ready_hi_since = 0;

    function automatic int spacing(input logic [2:0] op);
        case (op)
            3'd1:    return T_RP;
            3'd2:    return T_RCD;
            3'd3:    return T_RFC;
            3'd4:    return T_ZQCS;
            3'd5:    return T_MOD;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge ck) begin : p_cmp
        logic [3:0]  a_pins, e_pins;
        logic        e_rstn, e_cke, e_done, e_ready, e_err;
        logic [2:0]  e_ba;
        logic [13:0] e_addr;
        bit          c_bank, c_addr, c_a10;

        a_pins  = {cs_n, ras_n, cas_n, we_n};
        e_ready = 1'b0;
        if (model_on) begin
            e_rstn = (cyc >= T_RST);
            e_cke  = (cyc >= T_RST + T_CKE);
            e_pins = e_cke ? 4'b0111 : 4'b1111;
            e_ba   = '0;
            e_addr = '0;
            c_bank = 0; c_addr = 0; c_a10 = 0;
            if (cyc == TM2) begin e_pins = 4'b0000; e_ba = 3'd2; e_addr = MR2; c_bank = 1; c_addr = 1; end
            if (cyc == TM3) begin e_pins = 4'b0000; e_ba = 3'd3; e_addr = MR3; c_bank = 1; c_addr = 1; end
            if (cyc == TM1) begin e_pins = 4'b0000; e_ba = 3'd1; e_addr = MR1; c_bank = 1; c_addr = 1; end
            if (cyc == TM0) begin e_pins = 4'b0000; e_ba = 3'd0; e_addr = MR0; c_bank = 1; c_addr = 1; end
            if (cyc == TZQ) begin e_pins = 4'b0110; c_a10 = 1; end
            e_done  = (cyc >= TIDLE);
            e_ready = e_done && (cyc >= next_ready);
            e_err   = 1'b0;
            if (pend_v && pend_cyc == cyc) begin
                e_ba = pend_ba; e_addr = pend_addr; c_bank = 1; c_addr = 1;
                case (pend_op)
                    3'd0: begin e_pins = 4'b0111; c_bank = 0; c_addr = 0; end
                    3'd1: e_pins = 4'b0010;
                    3'd2: e_pins = 4'b0011;
                    3'd3: e_pins = 4'b0001;
                    3'd4: e_pins = 4'b0110;
                    3'd5: e_pins = 4'b0000;
                    default: begin e_pins = 4'b0111; e_err = 1'b1; c_bank = 0; c_addr = 0; end
                endcase
            end
            chk("ddr_rst_n", 32'(ddr_rst_n), 32'(e_rstn));
            chk("cke", 32'(cke), 32'(e_cke));
            chk("cmd_pins", 32'(a_pins), 32'(e_pins));
            chk("odt", 32'(odt), 32'd0);
            chk("init_done", 32'(init_done), 32'(e_done));
            chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
            chk("cmd_err", 32'(cmd_err), 32'(e_err));
            if (c_bank) chk("ba", 32'(ba), 32'(e_ba));
            if (c_addr) chk("addr", 32'(addr), 32'(e_addr));
            if (c_a10)  chk("zqcl_a10", 32'(addr[10]), 32'd1);

            // Hand-computed init timeline for the bench's parameter set.
            if (cyc == 3)  chk("lit_rstn_c3", 32'(ddr_rst_n), 32'd0);
            if (cyc == 4)  chk("lit_rstn_c4", 32'(ddr_rst_n), 32'd1);
            if (cyc == 9)  chk("lit_cke_c9", 32'(cke), 32'd0);
            if (cyc == 10) chk("lit_cke_c10", 32'(cke), 32'd1);
            if (cyc == 15) chk("lit_mr2_c15", 32'({a_pins, ba}), 32'({4'b0000, 3'd2}));
            if (cyc == 19) chk("lit_mr3_c19", 32'({a_pins, ba}), 32'({4'b0000, 3'd3}));
            if (cyc == 23) chk("lit_mr1_c23", 32'({a_pins, ba}), 32'({4'b0000, 3'd1}));
            if (cyc == 27) chk("lit_mr0_c27", 32'({a_pins, ba, addr}), 32'({4'b0000, 3'd0, 14'h0520}));
            if (cyc == 39) chk("lit_zqcl_c39", 32'({a_pins, addr[10]}), 32'({4'b0110, 1'b1}));
            if (cyc == 58) chk("lit_done_c58", 32'(init_done), 32'd0);
            if (cyc == 59) chk("lit_done_c59", 32'({init_done, cmd_ready}), 32'd3);

            if (mode == 5 && cyc < 59 && cmd_valid) chk("preinit_no_ready", 32'(cmd_ready), 32'd0);
            if (mode == 4 && cmd_valid) chk("nop_burst_ready", 32'(cmd_ready), 32'd1);
            if (mode == 3 && cmd_err) chk("illegal_pins_nop", 32'(a_pins), 32'h7);

            // Directed spacing measured purely from the observed pins.
            if (a_pins[3] == 1'b0 && a_pins != 4'b0111) begin
                if (mode == 1 && a_pins == 4'b0010 && obs_last == 4'b0011) begin
                    chk("act_to_pre_cycles", 32'(cyc - obs_last_cyc), 32'd6);
                    chk("pre_ap_bit", 32'(addr[10]), 32'd0);
                end
                if (mode == 2 && a_pins == 4'b0011 && obs_last == 4'b0001) begin
                    chk("ref_to_act_nops", 32'(nops_since), 32'd43);
                    chk("ref_gap_ready_cycles", 32'(ready_hi_since), 32'd1);
                end
                obs_last       = a_pins;
                obs_last_cyc   = cyc;
                nops_since     = 0;
                ready_hi_since = 0;
            end else if (a_pins == 4'b0111) begin
                nops_since++;
                if (cmd_ready) ready_hi_since++;
            end
        end

        if (model_on && cmd_valid && e_ready) begin
            pend_v     = 1'b1;
            pend_cyc   = cyc + 1;
            pend_op    = cmd_op;
            pend_ba    = cmd_ba;
            pend_addr  = cmd_addr;
            next_ready = cyc + spacing(cmd_op);
        end
        if (rst) begin
            model_on   = 1'b1;
            cyc        = 0;
            pend_v     = 1'b0;
            next_ready = 0;
        end else begin
            cyc++;
        end
    end

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] b, input logic [13:0] a);
        int n = 0;
        cmd_valid = 1'b0;
        @(negedge ck);
        while (!cmd_ready) begin
            if (n > 5000) begin
                $display("FAIL issue_timeout: cmd_ready got 0, expected 1");
                $fatal(1);
            end
            n++;
            @(negedge ck);
        end
        step();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ba    = b;
        cmd_addr  = a;
        step();
    endtask

    task automatic rand_cmd(input bit allow_valid);
        int r;
        r = int'($urandom % 16);
        cmd_valid = allow_valid ? 1'($urandom % 2) : 1'b0;
        if (r < 5)       cmd_op = 3'd0;
        else if (r < 8)  cmd_op = 3'd1;
        else if (r < 11) cmd_op = 3'd2;
        else if (r == 11) cmd_op = 3'd5;
        else if (r == 12) cmd_op = 3'd6;
        else if (r == 13) cmd_op = 3'd7;
        else if (r == 14) cmd_op = 3'd3;
        else             cmd_op = 3'd4;
        cmd_ba   = 3'($urandom);
        cmd_addr = 14'($urandom);
    endtask

    task automatic init_phase();
        mode = 5;
        repeat (58) begin
            rand_cmd(1'b1);
            step();
        end
        cmd_valid = 1'b0;
        mode = 0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ba = '0; cmd_addr = '0;
        repeat (3) step();
        rst = 1'b0;
        init_phase();

        mode = 1;
        issue(3'd2, 3'd3, 14'h1234);
        cmd_op = 3'd1; cmd_ba = 3'd3; cmd_addr = 14'($urandom) & ~14'h0400;
        repeat (T_RCD) step();
        cmd_valid = 1'b0;
        step();
        mode = 0;

        mode = 2;
        issue(3'd3, 3'd0, 14'h0000);
        cmd_op = 3'd2; cmd_ba = 3'd1; cmd_addr = 14'h0abc;
        repeat (T_RFC) step();
        cmd_valid = 1'b0;
        step();
        mode = 0;

        mode = 3;
        issue(3'd7, 3'd5, 14'h3fff);
        cmd_valid = 1'b0;
        repeat (2) step();
        mode = 0;

        mode = 4;
        issue(3'd0, 3'd0, 14'h0000);
        repeat (3) step();
        cmd_valid = 1'b0;
        mode = 0;

        repeat (800) begin
            rand_cmd(1'b1);
            step();
        end
        cmd_valid = 1'b0;

        issue(3'd3, 3'd2, 14'h0011);
        cmd_valid = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        init_phase();

        issue(3'd2, 3'd6, 14'h2aaa);
        cmd_valid = 1'b0;
        repeat (150) begin
            rand_cmd(1'b1);
            step();
        end
        cmd_valid = 1'b0;
        repeat (80) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
